// File: rtl/cnt_pkg.sv
// cnt_pkg: mode and direction encodings shared by the up/down counter
// Contents: cnt_mode_e (CNT_ALL, CNT_ODD, CNT_EVEN, CNT_HOLD), CNT_UP, CNT_DN
package cnt_pkg;
  typedef enum logic [1:0] {
    CNT_ALL  = 2'b00,
    CNT_ODD  = 2'b01,
    CNT_EVEN = 2'b10,
    CNT_HOLD = 2'b11
  } cnt_mode_e;
  localparam logic CNT_UP = 1'b0;
  localparam logic CNT_DN = 1'b1;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with asynchronous active-high reset to 0
// Ports: clk clock, rst async reset, T toggle enable, Q state
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic T,
  output logic Q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) Q <= 1'b0;
    else Q <= Q ^ T;
endmodule

// File: rtl/tff_updown_counter.sv
// tff_updown_counter: T-flip-flop up/down counter with all/odd/even/hold sequences
// Ports: clk, rst (async high), en, Y (0 up/1 down), mode, load, load_val -> Q, tc (comb), wrapped (registered pulse)
// Build option: define CNT_SATURATE_EN to hold at the terminal value instead of wrapping
module tff_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             Y,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrapped
);
  logic [WIDTH-1:0] next_q, term, delta, stepped, ld_q;
  logic aligned, at_term, adv, wrap_d;
  assign aligned = mode == CNT_ALL || mode == CNT_HOLD || Q[0] == (mode == CNT_ODD);
  // up: sequence max (even mode excludes all-ones); down: sequence min (odd mode starts at 1)
  assign term = Y == CNT_DN ? {{(WIDTH-1){1'b0}}, mode == CNT_ODD}
                            : {{(WIDTH-1){1'b1}}, mode != CNT_EVEN};
  assign at_term = aligned && Q == term;
  assign tc = mode != CNT_HOLD && at_term;
  assign adv = en && mode != CNT_HOLD;
  // misaligned parity moves by one to realign; modular step lands on the sequence start at terminal
  assign delta = !aligned ? WIDTH'(1) : mode == CNT_ALL ? WIDTH'(1) : WIDTH'(2);
  assign stepped = Y == CNT_DN ? Q - delta : Q + delta;
  assign ld_q = {load_val[WIDTH-1:1],
                 mode == CNT_ODD ? 1'b1 : mode == CNT_EVEN ? 1'b0 : load_val[0]};
`ifdef CNT_SATURATE_EN
  assign next_q = load ? ld_q : (adv && !at_term) ? stepped : Q;
  assign wrap_d = 1'b0;
`else
  assign next_q = load ? ld_q : adv ? stepped : Q;
  assign wrap_d = !load && adv && at_term;
`endif
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_cell (
      .clk(clk),
      .rst(rst),
      .T  (Q[i] ^ next_q[i]),
      .Q  (Q[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) wrapped <= 1'b0;
    else wrapped <= wrap_d;
endmodule

// File: doc/tff_updown_counter.md
TFF_UPDOWN_COUNTER -- requirements
Module: tff_updown_counter

Interface
REQ-001 Parameter: WIDTH, 4, counter width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  count enable; sampled on rising clk.
REQ-005 Port: Y  input  1  direction; 0 = up, 1 = down.
REQ-006 Port: mode  input  2  sequence select: 00 all values, 01 odd only, 10 even only, 11 hold.
REQ-007 Port: load  input  1  synchronous load strobe.
REQ-008 Port: load_val  input  WIDTH  value to load.
REQ-009 Port: Q  output  WIDTH  current count.
REQ-010 Port: tc  output  1  terminal count; combinational.
REQ-011 Port: wrapped  output  1  registered one-cycle pulse after a wrap.

Function
REQ-012 Priority per edge SHALL be: rst > load > (en and mode != 11) > hold.
REQ-013 Load SHALL set Q = load_val, with the LSB forced to 1 in mode 01 and to 0 in mode 10; one-cycle latency; load is honoured even when en=0 or mode=11.
REQ-014 Step size SHALL be 1 in mode 00 and 2 in modes 01 and 10; arithmetic is modulo 2^WIDTH.
REQ-015 Realign: in mode 01/10, if the LSB of Q does not match the mode parity, the enabled edge SHALL move Q by 1 in the direction of Y; this edge is not a wrap.
REQ-016 Sequence for WIDTH=4, mode 01, up: 1,3,...,15,1; down: 15,13,...,1,15.
REQ-017 Sequence for mode 10, up: 0,2,...,14,0.
REQ-018 Terminal value SHALL be the sequence maximum when counting up and the sequence minimum when counting down.
  - mode 00: max 2^W-1, min 0
  - mode 01: max 2^W-1, min 1
  - mode 10: max 2^W-2, min 0
REQ-019 tc SHALL be 1 iff Q equals the terminal value for the current Y/mode, Q is parity-aligned, and mode != 11; tc is independent of en.
REQ-020 wrapped SHALL pulse for exactly one cycle following each enabled edge that passes the terminal value back to the sequence start.
REQ-021 A change of Y or mode SHALL take effect on the next enabled edge, with no lost or extra step.
REQ-022 Q SHALL be held by T flip-flops; the toggle vector is Q XOR next_Q.

Reset
REQ-023 Asserting rst SHALL immediately force Q = 0 and wrapped = 0, including in the middle of a count or a load.
REQ-024 After rst deasserts, the first enabled edge SHALL follow REQ-015, so mode 01 leaves 0 through realignment.

Configuration
REQ-025 Macro CNT_SATURATE_EN defined: at the terminal value, an enabled edge SHALL hold Q, tc stays 1 and wrapped never asserts; reversing Y resumes counting.
REQ-026 Macro CNT_SATURATE_EN undefined: the counter SHALL wrap per REQ-014 to REQ-020.

Structure
REQ-027 Package cnt_pkg SHALL hold the mode encodings CNT_ALL, CNT_ODD, CNT_EVEN and CNT_HOLD, plus the direction constants CNT_UP and CNT_DN.
REQ-028 Sub-module tff_cell SHALL be a single T flip-flop (ports: Q, T, clk, rst; async active-high reset to 0), instantiated WIDTH times in a generate loop.
REQ-029 Next-state and terminal-value logic SHALL be in tff_updown_counter.

Verification (WIDTH=4)
REQ-030 Reset, then mode=01, Y=0, en=1 -> Q = 0,1,3,5,...,15,1; wrapped high for exactly one cycle while Q=1 after 15; tc=1 only while Q=15.
REQ-031 Starting from Q=5, mode=01, Y=1 -> Q = 3,1,15; tc=1 at Q=1; wrapped pulses after 15 is reached.
REQ-032 load=1, load_val=4'b0110, mode=01, en=0 -> Q=7 next edge; repeat with mode=10 -> Q=6.
REQ-033 Mid-count assertion of rst between clock edges -> Q=0 immediately, not at the next edge; counting resumes after deassert.
REQ-034 With CNT_SATURATE_EN, mode=00, Y=0 from Q=14 -> Q = 15,15,15; tc stays 1; wrapped stays 0; then Y=1 -> Q=14.
REQ-035 From Q=9, mode=11 with en=1 -> Q holds 9 and tc=0; then mode=10, Y=0 -> Q=10 (realign), then 12.
